// File: rtl/encoder_pkg.sv
// Shared state encoding and helper functions for the
// scanning priority encoder.
package encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + 7'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/prio_find_nbit.sv
// Combinational N-bit priority search: index of the
// highest-priority set bit plus an any-set flag.
module prio_find_nbit
  import encoder_pkg::*;
#(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1,
  localparam int W        = clog2(N)
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < N; i++) begin
        if (req_i[i]) idx_o = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req_i[i]) idx_o = W'(i);
      end
    end
  end

endmodule

// File: rtl/encoder_scan_nbit.sv
// Scanning priority encoder: loads a request vector and
// emits one index beat per set bit, in priority order.
module encoder_scan_nbit
  import encoder_pkg::*;
#(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1,
  localparam int W        = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] load_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic [W:0]   remain,
  output logic         none
);

  state_e       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic         none_q, none_d;
  logic [W-1:0] idx;
  logic         any;
  logic [N-1:0] clr;
  logic [6:0]   cnt;

  prio_find_nbit #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_find (
    .req_i (pend_q),
    .idx_o (idx),
    .any_o (any)
  );

  always_comb begin
    cnt = popcount(64'(pend_q));
    clr = '0;
    for (int i = 0; i < N; i++) begin
      clr[i] = any && (idx == W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      none_q  <= none_d;
    end
  end

  // In IDLE a load beats a simultaneous flush.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    none_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          if (|load_data) begin
            pend_d  = load_data;
            state_d = SCAN;
          end else begin
            none_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (flush) begin
          pend_d  = '0;
          state_d = IDLE;
        end else if (out_ready) begin
          pend_d = pend_q & ~clr;
          if (cnt == 7'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == IDLE);
    out_valid  = (state_q == SCAN);
    out_idx    = idx;
    out_last   = (cnt == 7'd1);
    remain     = cnt[W:0];
    none       = none_q;
  end

endmodule

// File: doc/encoder_scan_nbit.md
ENCODER_SCAN_NBIT -- requirements
Module: encoder_scan_nbit

Interface
REQ-001 SHALL have parameter N, default 8: request vector width, legal range 2..64.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit N-1 highest priority, 0 = bit 0 highest.
REQ-003 SHALL derive localparam W = clog2(N), minimum 1, as the index width.
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: load_valid  input  1  request vector offered.
REQ-007 Port: load_ready  output  1  block can accept a vector.
REQ-008 Port: load_data  input  N  request vector; bit i set = line i requesting.
REQ-009 Port: flush  input  1  abort current scan.
REQ-010 Port: out_valid  output  1  out_idx holds a valid encoded index.
REQ-011 Port: out_ready  input  1  consumer accepts out_idx.
REQ-012 Port: out_idx  output  W  index of highest-priority remaining set bit.
REQ-013 Port: out_last  output  1  current beat is the final set bit of the vector.
REQ-014 Port: remain  output  W+1  count of set bits not yet accepted.
REQ-015 Port: none  output  1  one-cycle pulse: accepted vector was all zero.

Function
REQ-016 SHALL implement two states: IDLE and SCAN.
REQ-017 IDLE: load_ready=1, out_valid=0; load handshake = load_valid & load_ready at a clock edge.
REQ-018 Load with load_data != 0: SHALL capture it into a pending register and enter SCAN; out_valid SHALL be 1 in the next cycle (1-cycle latency).
REQ-019 Load with load_data == 0: SHALL stay IDLE, pulse none=1 for exactly the next cycle, emit no beats.
REQ-020 SCAN: load_ready=0, out_valid=1; out_idx, out_last, remain SHALL derive from registered pending only (no combinational path from any input to any output).
REQ-021 out_idx SHALL be the index of the highest-priority set bit per MSB_FIRST; out_last=1 iff popcount(pending)==1; remain=popcount(pending).
REQ-022 Output handshake (out_valid & out_ready) SHALL clear the indexed bit of pending; next beat valid in the following cycle, giving one beat per cycle at out_ready=1 throughout.
REQ-023 out_idx/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Handshake on the out_last beat SHALL return to IDLE; load_ready=1 the following cycle.
REQ-025 flush=1 SHALL clear pending, force IDLE next cycle, and discard any simultaneous output handshake (no further beat); flush in IDLE SHALL not block a simultaneous load, and the load SHALL win.
REQ-026 A vector with K set bits SHALL yield exactly K beats, each index once, in strict priority order.
REQ-027 load_valid in SCAN SHALL be ignored; load_data not sampled.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, pending=0, none=0; from the next cycle outputs SHALL be load_ready=1, out_valid=0, out_idx=0, out_last=0, remain=0.
REQ-029 rst SHALL take priority over flush, load and output handshakes, including mid-scan; no beat after reset.

Structure
REQ-030 State encoding (IDLE, SCAN) and a clog2 helper function SHALL live in shared package encoder_pkg.
REQ-031 Priority search SHALL be a combinational sub-module prio_find_nbit (parameters N, MSB_FIRST; outputs index and any-set), generalising the 4-bit gate-level encoder's Aout/V function.
REQ-032 Popcount SHALL be a function in encoder_pkg; no other sub-modules.

Verification
REQ-033 N=8, MSB_FIRST=1: load 8'b1010_0101, out_ready=1 -> idx 7,5,2,0 on consecutive cycles, out_last only on 0, remain 4,3,2,1, load_ready=1 next cycle.
REQ-034 N=8, MSB_FIRST=0: load 8'b1010_0101 -> idx 0,2,5,7.
REQ-035 Load 8'h00 -> none=1 for one cycle, out_valid stays 0, load_ready stays 1.
REQ-036 Load 8'hFF, out_ready toggling 1,0,1,0 -> idx 7 then 6 held during stall, idx 6 accepted in the third cycle; exactly 8 beats total.
REQ-037 Load 8'hFF, flush after 3 beats -> IDLE next cycle, remain=0; then load 8'h01 -> single beat idx 0, out_last=1.
REQ-038 N=4 exhaustive: all 16 vectors, each beat checked against a reference priority-encoder model; rst asserted mid-scan on 4'hF -> out_valid=0 next cycle, no further beats.
